// File: rtl/xnor_compare_arbiter.sv
// Round-robin arbiter sharing one serial XNOR equality slice among NREQ requesters.
// Optional match-count output enabled by defining XNOR_ARB_POPCNT_EN.
module xnor_compare_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned SLICE_W = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rn,
  input  logic [NREQ-1:0]           i_req,
  input  logic [NREQ*WORD_W-1:0]    i_a_in,
  input  logic [NREQ*WORD_W-1:0]    i_b_in,
  output logic [NREQ-1:0]           o_gnt,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [$clog2(NREQ)-1:0]   o_done_id,
  output logic                      o_eq
`ifdef XNOR_ARB_POPCNT_EN
  ,
  output logic [$clog2(WORD_W+1)-1:0] o_match_cnt
`endif
);

  localparam int unsigned BEATS = WORD_W / SLICE_W;
  localparam int unsigned IDW   = $clog2(NREQ);
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CW    = $clog2(WORD_W + 1);

  if ((SLICE_W == 0) || ((WORD_W % SLICE_W) != 0)) begin : g_bad_cfg
    $error("xnor_compare_arbiter: WORD_W must be a multiple of SLICE_W");
  end

  typedef enum logic [1:0] {StIdle, StCmp, StFin} state_e;

  state_e              r_state, w_state_d;
  logic [IDW-1:0]      r_ptr, w_ptr_d;
  logic [BW-1:0]       r_beat, w_beat_d;
  logic                r_eq_acc, w_eq_acc_d;
  logic [WORD_W-1:0]   r_a, w_a_d;
  logic [WORD_W-1:0]   r_b, w_b_d;
  logic [NREQ-1:0]     r_gnt, w_gnt_d;
  logic                r_busy, w_busy_d;
  logic                r_done, w_done_d;
  logic [IDW-1:0]      r_done_id, w_done_id_d;
  logic                r_eq, w_eq_d;
`ifdef XNOR_ARB_POPCNT_EN
  logic [CW-1:0]       r_cnt_acc, w_cnt_acc_d;
  logic [CW-1:0]       r_match_cnt, w_match_cnt_d;
  logic [CW-1:0]       w_pop;
`endif

  logic [IDW-1:0]      w_win;
  logic                w_any;
  int unsigned         w_idx;
  logic [WORD_W-1:0]   w_a_sel, w_b_sel;
  logic [SLICE_W-1:0]  w_xnor;
  logic                w_eq_next;
  logic                w_last_beat;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    w_win = r_ptr;
    w_any = 1'b0;
    w_idx = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      w_idx = (32'(r_ptr) + i) % NREQ;
      if (!w_any && i_req[IDW'(w_idx)]) begin
        w_any = 1'b1;
        w_win = IDW'(w_idx);
      end
    end
  end

  always_comb begin
    w_a_sel = '0;
    w_b_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDW'(i) == w_win) begin
        w_a_sel = i_a_in[i*WORD_W +: WORD_W];
        w_b_sel = i_b_in[i*WORD_W +: WORD_W];
      end
    end
  end

  // Latched operands shift right each beat, so the current slice is always the low bits.
  assign w_xnor      = ~(r_a[SLICE_W-1:0] ^ r_b[SLICE_W-1:0]);
  assign w_eq_next   = r_eq_acc & (&w_xnor);
  assign w_last_beat = (r_beat == BW'(BEATS - 1));

`ifdef XNOR_ARB_POPCNT_EN
  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < SLICE_W; i++) begin
      w_pop = w_pop + CW'(w_xnor[i]);
    end
  end
`endif

  always_comb begin
    w_state_d   = r_state;
    w_ptr_d     = r_ptr;
    w_beat_d    = r_beat;
    w_eq_acc_d  = r_eq_acc;
    w_a_d       = r_a;
    w_b_d       = r_b;
    w_gnt_d     = '0;
    w_busy_d    = r_busy;
    w_done_d    = 1'b0;
    w_done_id_d = r_done_id;
    w_eq_d      = r_eq;
`ifdef XNOR_ARB_POPCNT_EN
    w_cnt_acc_d   = r_cnt_acc;
    w_match_cnt_d = r_match_cnt;
`endif
    unique case (r_state)
      StIdle: begin
        if (w_any) begin
          w_a_d      = w_a_sel;
          w_b_d      = w_b_sel;
          w_gnt_d    = NREQ'(1) << w_win;
          w_ptr_d    = w_win;
          w_beat_d   = '0;
          w_eq_acc_d = 1'b1;
          w_busy_d   = 1'b1;
          w_state_d  = StCmp;
`ifdef XNOR_ARB_POPCNT_EN
          w_cnt_acc_d = '0;
`endif
        end
      end
      StCmp: begin
        w_eq_acc_d = w_eq_next;
        w_beat_d   = r_beat + BW'(1);
        w_a_d      = r_a >> SLICE_W;
        w_b_d      = r_b >> SLICE_W;
`ifdef XNOR_ARB_POPCNT_EN
        w_cnt_acc_d = r_cnt_acc + w_pop;
`endif
        if (w_last_beat) begin
          w_state_d   = StFin;
          w_done_d    = 1'b1;
          w_eq_d      = w_eq_next;
          w_done_id_d = r_ptr;
`ifdef XNOR_ARB_POPCNT_EN
          w_match_cnt_d = r_cnt_acc + w_pop;
`endif
        end
      end
      StFin: begin
        w_busy_d  = 1'b0;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rn) begin
    if (!i_rn) begin
      r_state   <= StIdle;
      r_ptr     <= IDW'(NREQ - 1);
      r_beat    <= '0;
      r_eq_acc  <= 1'b1;
      r_a       <= '0;
      r_b       <= '0;
      r_gnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= '0;
      r_eq      <= 1'b0;
`ifdef XNOR_ARB_POPCNT_EN
      r_cnt_acc   <= '0;
      r_match_cnt <= '0;
`endif
    end else begin
      r_state   <= w_state_d;
      r_ptr     <= w_ptr_d;
      r_beat    <= w_beat_d;
      r_eq_acc  <= w_eq_acc_d;
      r_a       <= w_a_d;
      r_b       <= w_b_d;
      r_gnt     <= w_gnt_d;
      r_busy    <= w_busy_d;
      r_done    <= w_done_d;
      r_done_id <= w_done_id_d;
      r_eq      <= w_eq_d;
`ifdef XNOR_ARB_POPCNT_EN
      r_cnt_acc   <= w_cnt_acc_d;
      r_match_cnt <= w_match_cnt_d;
`endif
    end
  end

  assign o_gnt     = r_gnt;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_done_id = r_done_id;
  assign o_eq      = r_eq;
`ifdef XNOR_ARB_POPCNT_EN
  assign o_match_cnt = r_match_cnt;
`endif

endmodule

// File: tb/tb_xnor_compare_arbiter.sv
// Self-checking bench for xnor_compare_arbiter: directed scenarios plus random
// transactions checked against a round-robin / word-compare reference model.
module tb_xnor_compare_arbiter;

  localparam int NREQ    = 2;
  localparam int WORD_W  = 32;
  localparam int SLICE_W = 8;
  localparam int BEATS   = WORD_W / SLICE_W;

  logic                   clk = 1'b0;
  logic                   rn  = 1'b0;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*WORD_W-1:0] a_in = '0;
  logic [NREQ*WORD_W-1:0] b_in = '0;
  logic [NREQ-1:0]        gnt;
  logic                   busy, done, eq;
  logic [0:0]             done_id;
`ifdef XNOR_ARB_POPCNT_EN
  logic [5:0]             match_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int m_ptr    = NREQ - 1;  // model round-robin pointer
  int m_eq     = 0;         // model of the held EQ output

  always #5 clk = ~clk;

  xnor_compare_arbiter #(
    .NREQ   (NREQ),
    .WORD_W (WORD_W),
    .SLICE_W(SLICE_W)
  ) dut (
    .i_clk    (clk),
    .i_rn     (rn),
    .i_req    (req),
    .i_a_in   (a_in),
    .i_b_in   (b_in),
    .o_gnt    (gnt),
    .o_busy   (busy),
    .o_done   (done),
    .o_done_id(done_id),
    .o_eq     (eq)
`ifdef XNOR_ARB_POPCNT_EN
    ,
    .o_match_cnt(match_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int i = 1; i <= NREQ; i++) begin
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  // One full arbitration: wait for grant, then expect DONE exactly BEATS cycles later.
  task automatic run_txn(input logic [NREQ-1:0] r, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [31:0] a1, input logic [31:0] b1, input bit hold,
                         input bit clobber, input int exp_wait);
    int w;
    int waited;
    logic [31:0] ea, eb;
    req  = r;
    a_in = {a1, a0};
    b_in = {b1, b0};
    w = rr_pick(r, m_ptr);
    m_ptr = w;
    ea = (w == 1) ? a1 : a0;
    eb = (w == 1) ? b1 : b0;
    waited = 0;
    do begin
      step();
      waited++;
    end while (gnt == '0 && waited < 20);
    chk("gnt_onehot", gnt, 32'(1) << w);
    chk("busy_at_gnt", busy, 1);
    if (exp_wait > 0) chk("gnt_spacing", waited, exp_wait);
    if (!hold) req[w] = 1'b0;
    if (clobber) begin
      a_in[w*WORD_W +: WORD_W] = ~ea;
      b_in[w*WORD_W +: WORD_W] = eb ^ 32'h0000_0100;
    end
    for (int k = 1; k < BEATS; k++) begin
      step();
      chk("done_early", done, 0);
      if (k == 1) chk("gnt_pulse", gnt, 0);
    end
    step();
    m_eq = (ea == eb) ? 1 : 0;
    chk("done_pulse", done, 1);
    chk("eq", eq, m_eq);
    chk("done_id", done_id, w);
    chk("busy_during", busy, 1);
`ifdef XNOR_ARB_POPCNT_EN
    chk("match_cnt", match_cnt, $countones(~(ea ^ eb)));
`endif
    step();
    chk("done_clear", done, 0);
    chk("busy_clear", busy, 0);
    chk("eq_hold", eq, m_eq);
  endtask

  initial begin
    logic [31:0] ra, rb, rc, rd;
    logic [NREQ-1:0] rr;

    // Reset state
    repeat (2) step();
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_eq", eq, 0);
    chk("rst_done_id", done_id, 0);
`ifdef XNOR_ARB_POPCNT_EN
    chk("rst_match_cnt", match_cnt, 0);
`endif
    rn = 1'b1;

    // Equal operands on requester 0
    run_txn(2'b01, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0, 1'b0, 1);
    repeat (3) begin
      step();
      chk("idle_no_gnt", gnt, 0);
    end

    // Mismatch confined to the last slice on requester 1
    run_txn(2'b10, 32'h0, 32'h0, 32'h0, 32'h8000_0000, 1'b0, 1'b0, 1);

    // Both requesting from reset: grants must alternate with 6-cycle spacing
    rn = 1'b0;
    #1;
    rn = 1'b1;
    m_ptr = NREQ - 1;
    for (int i = 0; i < 4; i++) begin
      ra = $urandom();
      rc = $urandom();
      run_txn(2'b11, ra, (i == 2) ? ra : ra ^ 32'h1, rc, (i == 1) ? rc : ~rc, 1'b1, 1'b0, 1);
    end
    req = '0;

    // Operand change after grant must not affect the result
    run_txn(2'b01, 32'h1234_5678, 32'h1234_5678, 32'h0, 32'h5, 1'b0, 1'b1, 1);

    // Reset during beat 2 abandons the compare
    req  = 2'b01;
    a_in = {32'h0, 32'hCAFE_F00D};
    b_in = {32'h0, 32'hCAFE_F00D};
    step();
    chk("rst_mid_gnt", gnt, 2'b01);
    req = '0;
    repeat (2) step();
    rn = 1'b0;
    #1;
    chk("rstm_gnt", gnt, 0);
    chk("rstm_busy", busy, 0);
    chk("rstm_done", done, 0);
    chk("rstm_eq", eq, 0);
    chk("rstm_done_id", done_id, 0);
    step();
    rn = 1'b1;
    m_ptr = NREQ - 1;
    m_eq = 0;
    repeat (6) begin
      step();
      chk("rstm_no_done", done, 0);
    end
    run_txn(2'b01, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 32'h0, 32'h0, 1'b0, 1'b0, 1);

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      rr = NREQ'($urandom_range(1, 3));
      ra = $urandom();
      rc = $urandom();
      rb = ($urandom_range(0, 1) == 1) ? ra : ra ^ (32'(1) << $urandom_range(0, 31));
      rd = ($urandom_range(0, 1) == 1) ? rc : $urandom();
      run_txn(rr, ra, rb, rc, rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
    end
    req = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
